// File: rtl/flash_stream_pkg.sv
// rtl/flash_stream_pkg.sv - shared state encoding and debug bus layout for the flash sample streamer
package flash_stream_pkg;
   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_REQ       = 4'd1,
      ST_WAIT_DATA = 4'd2,
      ST_EMIT      = 4'd3,
      ST_ADVANCE   = 4'd4
   } state_t;

   localparam int DBG_STATE_LSB = 12;
   localparam int DBG_LANE_LSB  = 8;
   localparam int DBG_WAIT_BIT  = 1;
   localparam int DBG_RDV_BIT   = 0;
endpackage

// File: rtl/flash_addr_stepper.sv
// rtl/flash_addr_stepper.sv - one-word address step forward or backward with wrap inside the sample region
module flash_addr_stepper #(
   parameter int                ADDR_W  = 23,
   parameter logic [ADDR_W-1:0] START_A = '0,
   parameter logic [ADDR_W-1:0] END_A   = '1
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              rev,
   output logic [ADDR_W-1:0] next_addr
);
   always_comb begin
      if (rev)
         next_addr = (addr == START_A) ? END_A : addr - ADDR_W'(1);
      else
         next_addr = (addr == END_A) ? START_A : addr + ADDR_W'(1);
   end
endmodule

// File: rtl/flash_sample_streamer.sv
// rtl/flash_sample_streamer.sv - fetches flash words and plays their packed samples forward or reverse on each sample tick
module flash_sample_streamer
   import flash_stream_pkg::*;
#(
   parameter int                DATA_W     = 32,
   parameter int                SAMPLE_W   = 16,
   parameter int                ADDR_W     = 23,
   parameter logic [ADDR_W-1:0] START_ADDR = '0,
   parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'('h7FFFF)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_tick,
   input  logic                pause,
   input  logic                reverse,
   input  logic                restart,
   output logic                flsh_read,
   output logic [ADDR_W-1:0]   flsh_address,
   output logic [DATA_W/8-1:0] flsh_byteenable,
   input  logic                flsh_waitrequest,
   input  logic [DATA_W-1:0]   flsh_readdata,
   input  logic                flsh_readdatavalid,
   output logic                audio_valid,
   output logic [SAMPLE_W-1:0] audio_out,
   output logic                overrun,
   output logic [15:0]         debug
);
   localparam int N      = DATA_W / SAMPLE_W;
   localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(N - 1);

   state_t              state;
   logic [DATA_W-1:0]   word_q;
   logic                buf_valid;
   logic [LANE_W-1:0]   lane;
   logic                dir_q;
   logic                restart_pend;
   logic                do_restart;
   logic                last_lane;
   logic [SAMPLE_W-1:0] lane_sample;
   logic [ADDR_W-1:0]   step_in;
   logic [ADDR_W-1:0]   step_out;

   // A restart lands on the region start by stepping once from the opposite end.
   always_comb begin
      do_restart  = restart | restart_pend;
      last_lane   = dir_q ? (lane == '0) : (lane == LANE_LAST);
      lane_sample = word_q[int'(lane)*SAMPLE_W +: SAMPLE_W];
      if (state == ST_ADVANCE)
         step_in = flsh_address;
      else
         step_in = reverse ? START_ADDR : END_ADDR;
   end

   flash_addr_stepper #(
      .ADDR_W  (ADDR_W),
      .START_A (START_ADDR),
      .END_A   (END_ADDR)
   ) u_stepper (
      .addr      (step_in),
      .rev       (reverse),
      .next_addr (step_out)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         flsh_read    <= 1'b0;
         flsh_address <= START_ADDR;
         audio_valid  <= 1'b0;
         audio_out    <= '0;
         overrun      <= 1'b0;
         word_q       <= '0;
         buf_valid    <= 1'b0;
         lane         <= '0;
         dir_q        <= 1'b0;
         restart_pend <= 1'b0;
      end else begin
         audio_valid <= 1'b0;
         if (sample_tick && state != ST_IDLE)
            overrun <= 1'b1;
         if (restart && state != ST_IDLE)
            restart_pend <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (do_restart) begin
                  flsh_address <= step_out;
                  buf_valid    <= 1'b0;
                  lane         <= reverse ? LANE_LAST : '0;
                  dir_q        <= reverse;
                  restart_pend <= 1'b0;
               end
               if (sample_tick && !pause) begin
                  if (buf_valid && !do_restart) begin
                     state <= ST_EMIT;
                  end else begin
                     state     <= ST_REQ;
                     flsh_read <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               if (!flsh_waitrequest) begin
                  flsh_read <= 1'b0;
                  state     <= ST_WAIT_DATA;
               end
            end
            ST_WAIT_DATA: begin
               if (flsh_readdatavalid) begin
                  word_q    <= flsh_readdata;
                  buf_valid <= 1'b1;
                  state     <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               audio_out   <= lane_sample;
               audio_valid <= 1'b1;
               if (last_lane) begin
                  state <= ST_ADVANCE;
               end else begin
                  lane  <= dir_q ? lane - LANE_W'(1) : lane + LANE_W'(1);
                  state <= ST_IDLE;
               end
            end
            ST_ADVANCE: begin
               buf_valid    <= 1'b0;
               dir_q        <= reverse;
               flsh_address <= step_out;
               lane         <= reverse ? LANE_LAST : '0;
               state        <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign flsh_byteenable = '1;

   always_comb begin
      debug                           = '0;
      debug[DBG_STATE_LSB +: 4]       = state;
      debug[DBG_LANE_LSB +: 4]        = 4'(lane);
      debug[DBG_WAIT_BIT]             = flsh_waitrequest;
      debug[DBG_RDV_BIT]              = flsh_readdatavalid;
   end
endmodule

// File: tb/tb_flash_sample_streamer.sv
// tb/tb_flash_sample_streamer.sv - self-checking bench for flash_sample_streamer against a sample-sequence model
module tb_flash_sample_streamer;
   localparam int LAT = 2;
   localparam int NL  = 2;
   localparam logic [7:0] START = 8'd0;
   localparam logic [7:0] ENDA  = 8'd3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sample_tick = 1'b0;
   logic        pause = 1'b0;
   logic        reverse = 1'b0;
   logic        restart = 1'b0;
   logic        flsh_read;
   logic [7:0]  flsh_address;
   logic [3:0]  flsh_byteenable;
   logic        flsh_waitrequest = 1'b0;
   logic [31:0] flsh_readdata;
   logic        flsh_readdatavalid;
   logic        audio_valid;
   logic [15:0] audio_out;
   logic        overrun;
   logic [15:0] debug;

   logic [31:0] mem [0:3];
   logic        rsp_rdv = 1'b0;
   logic [31:0] rsp_data = '0;
   logic        spur = 1'b0;
   int          wait_n = 0, wctr = 0, pend = 0, accepted = 0;
   logic [7:0]  pend_addr = '0, last_acc_addr = '0;

   int          n_cmp = 0, n_fail = 0;
   int          m_addr, m_lane;
   bit          m_dir, m_buf;

   assign flsh_readdatavalid = rsp_rdv | spur;
   assign flsh_readdata      = spur ? 32'hDEAD_DEAD : rsp_data;

   flash_sample_streamer #(
      .DATA_W(32), .SAMPLE_W(16), .ADDR_W(8), .START_ADDR(START), .END_ADDR(ENDA)
   ) dut (
      .clk(clk), .reset(reset), .sample_tick(sample_tick), .pause(pause),
      .reverse(reverse), .restart(restart), .flsh_read(flsh_read),
      .flsh_address(flsh_address), .flsh_byteenable(flsh_byteenable),
      .flsh_waitrequest(flsh_waitrequest), .flsh_readdata(flsh_readdata),
      .flsh_readdatavalid(flsh_readdatavalid), .audio_valid(audio_valid),
      .audio_out(audio_out), .overrun(overrun), .debug(debug)
   );

   always #5 clk = ~clk;

   // Avalon flash: wait_n stall cycles per request, data LAT cycles after acceptance.
   always @(negedge clk) begin
      rsp_rdv = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            rsp_rdv  = 1'b1;
            rsp_data = mem[pend_addr[1:0]];
         end
      end
      if (flsh_read && !reset) begin
         if (wctr < wait_n) begin
            flsh_waitrequest = 1'b1;
            wctr++;
         end else begin
            flsh_waitrequest = 1'b0;
            wctr = 0;
            accepted++;
            last_acc_addr = flsh_address;
            pend_addr = flsh_address;
            pend = LAT;
         end
      end else begin
         flsh_waitrequest = 1'b0;
         wctr = 0;
      end
   end

   function automatic int wrap_step(input int a, input bit rev);
      if (rev) return (a == int'(START)) ? int'(ENDA) : a - 1;
      return (a == int'(ENDA)) ? int'(START) : a + 1;
   endfunction

   task automatic model_reset();
      m_addr = int'(START); m_lane = 0; m_dir = 0; m_buf = 0;
   endtask

   task automatic model_restart();
      m_addr = reverse ? int'(ENDA) : int'(START);
      m_lane = reverse ? NL - 1 : 0;
      m_dir  = reverse;
      m_buf  = 0;
   endtask

   task automatic pulse_restart();
      @(negedge clk); restart = 1'b1;
      @(negedge clk); restart = 1'b0;
      model_restart();
   endtask

   task automatic do_tick(input bit with_restart, input int wn);
      logic [15:0] exp_s;
      bit exp_fetch, got, last;
      int exp_addr, acc0, lat, exp_lat;
      wait_n = wn;
      if (with_restart) model_restart();
      exp_fetch = !m_buf;
      exp_addr  = m_addr;
      exp_s     = mem[m_addr][m_lane*16 +: 16];
      m_buf     = 1;
      last      = m_dir ? (m_lane == 0) : (m_lane == NL - 1);
      if (last) begin
         m_buf  = 0;
         m_dir  = reverse;
         m_addr = wrap_step(m_addr, reverse);
         m_lane = reverse ? NL - 1 : 0;
      end else begin
         m_lane = m_dir ? m_lane - 1 : m_lane + 1;
      end
      acc0 = accepted;
      @(negedge clk); sample_tick = 1'b1; restart = with_restart;
      @(negedge clk); sample_tick = 1'b0; restart = 1'b0;
      got = 0; lat = 0;
      for (int k = 1; k <= 40 && !got; k++) begin
         if (k > 1) @(negedge clk);
         if (audio_valid) begin got = 1; lat = k; end
      end
      exp_lat = exp_fetch ? 5 + wn : 2;
      n_cmp++;
      if (!got) begin
         n_fail++; $display("FAIL tick_valid: no audio_valid within 40 cycles, expected one");
      end else begin
         n_cmp++;
         if (audio_out !== exp_s) begin
            n_fail++; $display("FAIL tick_sample: got %h expected %h", audio_out, exp_s);
         end
         n_cmp++;
         if (lat != exp_lat) begin
            n_fail++; $display("FAIL tick_latency: got %0d expected %0d", lat, exp_lat);
         end
      end
      n_cmp++;
      if (accepted - acc0 != int'(exp_fetch)) begin
         n_fail++; $display("FAIL tick_fetches: got %0d expected %0d", accepted - acc0, exp_fetch);
      end
      if (exp_fetch) begin
         n_cmp++;
         if (int'(last_acc_addr) != exp_addr) begin
            n_fail++; $display("FAIL tick_addr: got %0d expected %0d", last_acc_addr, exp_addr);
         end
      end
      @(negedge clk); @(negedge clk);
   endtask

   task automatic test_reset();
      n_cmp += 5;
      if (flsh_read !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b expected 0", flsh_read); end
      if (flsh_address !== START) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", flsh_address, START); end
      if ({audio_valid, overrun} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {audio_valid, overrun}); end
      if (audio_out !== 16'h0) begin n_fail++; $display("FAIL reset_audio: got %h expected 0000", audio_out); end
      if (debug !== 16'h0000 || flsh_byteenable !== 4'hF) begin
         n_fail++; $display("FAIL reset_debug_be: got %h/%h expected 0000/f", debug, flsh_byteenable);
      end
   endtask

   task automatic test_forward();
      do_tick(0, 0);
      do_tick(0, 0);
      do_tick(0, 0);
      n_cmp++;
      if (last_acc_addr !== 8'd1) begin n_fail++; $display("FAIL fwd_next_word: got %h expected 01", last_acc_addr); end
   endtask

   task automatic test_reverse_wrap();
      reverse = 1'b1;
      pulse_restart();
      n_cmp++;
      if (flsh_address !== ENDA) begin n_fail++; $display("FAIL rev_restart_addr: got %h expected %h", flsh_address, ENDA); end
      for (int i = 0; i < 8; i++) do_tick(0, 0);
      n_cmp++;
      if (flsh_address !== ENDA) begin n_fail++; $display("FAIL rev_wrap_addr: got %h expected %h", flsh_address, ENDA); end
   endtask

   task automatic test_fwd_wrap();
      reverse = 1'b0;
      pulse_restart();
      for (int i = 0; i < 8; i++) do_tick(0, 0);
      n_cmp++;
      if (flsh_address !== START) begin n_fail++; $display("FAIL fwd_wrap_addr: got %h expected %h", flsh_address, START); end
   endtask

   task automatic test_pause();
      int seen = 0;
      logic [7:0] a0;
      pulse_restart();
      a0 = flsh_address;
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); sample_tick = 1'b1;
         @(negedge clk); sample_tick = 1'b0;
         if (flsh_read || audio_valid) seen++;
         @(negedge clk);
         if (flsh_read || audio_valid) seen++;
      end
      pause = 1'b0;
      n_cmp += 2;
      if (seen != 0) begin n_fail++; $display("FAIL pause_activity: got %0d active cycles expected 0", seen); end
      if (flsh_address !== a0) begin n_fail++; $display("FAIL pause_addr: got %h expected %h", flsh_address, a0); end
      do_tick(0, 0);
   endtask

   task automatic test_restart_with_tick();
      do_tick(0, 0);
      reverse = 1'b1;
      do_tick(1, 1);
      do_tick(0, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 3) == 0) reverse = $urandom_range(0, 1);
         do_tick($urandom_range(0, 5) == 0, $urandom_range(0, 2));
      end
   endtask

   task automatic test_spurious();
      reverse = 1'b0;
      pulse_restart();
      do_tick(0, 0);
      @(negedge clk); spur = 1'b1;
      @(negedge clk); spur = 1'b0;
      do_tick(0, 0);
   endtask

   task automatic test_waitreq_overrun();
      int acc0, rd_cycles = 0, unstable = 0;
      bit rd_seen = 0, ticked = 0, got = 0;
      logic [7:0] a_first = '0;
      logic [15:0] exp_s;
      pulse_restart();
      exp_s = mem[m_addr][m_lane*16 +: 16];
      wait_n = 5;
      acc0 = accepted;
      @(negedge clk); sample_tick = 1'b1;
      @(negedge clk); sample_tick = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         if (flsh_read) begin
            if (!rd_seen) a_first = flsh_address;
            else if (flsh_address !== a_first) unstable++;
            rd_seen = 1; rd_cycles++;
         end else if (rd_seen && !ticked) begin
            sample_tick = 1'b1; ticked = 1;
         end
         if (audio_valid) got = 1;
         @(negedge clk); sample_tick = 1'b0;
      end
      m_buf = 1; m_lane = 1;
      n_cmp += 5;
      if (rd_cycles != 6) begin n_fail++; $display("FAIL wr_read_cycles: got %0d expected 6", rd_cycles); end
      if (unstable != 0) begin n_fail++; $display("FAIL wr_addr_stable: got %0d changes expected 0", unstable); end
      if (accepted - acc0 != 1) begin n_fail++; $display("FAIL wr_accepts: got %0d expected 1", accepted - acc0); end
      if (!got || audio_out !== exp_s) begin n_fail++; $display("FAIL wr_sample: got %h expected %h", audio_out, exp_s); end
      if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b expected 1", overrun); end
      @(negedge clk); @(negedge clk);
      do_tick(0, 0);
      n_cmp++;
      if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
   endtask

   task automatic test_reset_mid();
      int av = 0;
      bit rd_seen = 0, done = 0;
      wait_n = 0;
      pulse_restart();
      @(negedge clk); sample_tick = 1'b1;
      @(negedge clk); sample_tick = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         if (flsh_read) rd_seen = 1;
         else if (rd_seen) done = 1;
         if (!done) @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (audio_valid) av++;
         @(negedge clk);
      end
      model_reset();
      n_cmp += 5;
      if (!done) begin n_fail++; $display("FAIL rst_mid_wait: no fetch reached WAIT_DATA, expected one"); end
      if (av != 0) begin n_fail++; $display("FAIL rst_mid_valid: got %0d strobes expected 0", av); end
      if (flsh_address !== START) begin n_fail++; $display("FAIL rst_mid_addr: got %h expected %h", flsh_address, START); end
      if (debug[15:12] !== 4'd0 || flsh_read !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_state: got state %0d read %b expected 0/0", debug[15:12], flsh_read);
      end
      if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_mid_overrun: got %b expected 0", overrun); end
      do_tick(0, 0);
   endtask

   initial begin
      mem[0] = 32'hBEEF_1234;
      for (int i = 1; i < 4; i++) mem[i] = $urandom;
      model_reset();
      repeat (3) @(negedge clk);
      test_reset();
      reset = 1'b0;
      test_forward();
      test_reverse_wrap();
      test_fwd_wrap();
      test_pause();
      test_restart_with_tick();
      test_random();
      test_spurious();
      test_waitreq_overrun();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
